// File: rtl/adder_pipe_scheduler_if.sv
// Handshake, adder and response bundle for adder_pipe_scheduler.
// The master modport is the scheduler side; the slave modport is the requester/adder/consumer side.
interface adder_pipe_scheduler_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req0_cin;
    logic        req1_cin;
    logic        flush;
    logic [31:0] pipe_a;
    logic [31:0] pipe_b;
    logic        pipe_cin;
    logic [3:0]  pipe_halt;
    logic [3:0]  pipe_refresh;
    logic [31:0] pipe_sum;
    logic        pipe_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_id;

    modport master (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, flush, pipe_sum, pipe_cout, rsp_ready,
        output req0_ready, req1_ready, pipe_a, pipe_b, pipe_cin, pipe_halt,
               pipe_refresh, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, flush, pipe_sum, pipe_cout, rsp_ready,
        input  req0_ready, req1_ready, pipe_a, pipe_b, pipe_cin, pipe_halt,
               pipe_refresh, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );
endinterface

// File: rtl/adder_pipe_scheduler.sv
// Two-requester front end for a 4-stage pipelined adder with credit-limited response FIFO.
// Define PIPE_ADDER_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module adder_pipe_scheduler #(
    parameter int DEPTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    adder_pipe_scheduler_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [33:0]   r_mem [DEPTH];
    logic [3:0]    r_v;
    logic [3:0]    r_id;

    logic          w_issueOk;
    logic          w_pref1;
    logic          w_ready0;
    logic          w_ready1;
    logic          w_issue0;
    logic          w_issue1;
    logic          w_issue;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_flushed;

`ifdef PIPE_ADDER_RR_EN
    logic r_pref1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pref1 <= 1'b0;
        end else if (w_issue) begin
            r_pref1 <= w_issue0;
        end
    end

    assign w_pref1 = r_pref1;
`else
    assign w_pref1 = 1'b0;
`endif

    // A requester's ready depends only on credit and whether the other side would win contention.
    assign w_issueOk = rst_n & ~bus.flush & (r_outstanding < CW'(DEPTH));
    assign w_ready0  = w_issueOk & ~(bus.req1_valid & w_pref1);
    assign w_ready1  = w_issueOk & ~(bus.req0_valid & ~w_pref1);
    assign w_issue0  = bus.req0_valid & w_ready0;
    assign w_issue1  = bus.req1_valid & w_ready1;
    assign w_issue   = w_issue0 | w_issue1;

    assign bus.req0_ready   = w_ready0;
    assign bus.req1_ready   = w_ready1;
    assign bus.pipe_halt    = 4'b0000;
    assign bus.pipe_refresh = (!rst_n || bus.flush) ? 4'b1111 : 4'b0000;

    always_comb begin
        bus.pipe_a   = '0;
        bus.pipe_b   = '0;
        bus.pipe_cin = 1'b0;
        if (w_issue0) begin
            bus.pipe_a   = bus.req0_a;
            bus.pipe_b   = bus.req0_b;
            bus.pipe_cin = bus.req0_cin;
        end else if (w_issue1) begin
            bus.pipe_a   = bus.req1_a;
            bus.pipe_b   = bus.req1_b;
            bus.pipe_cin = bus.req1_cin;
        end
    end

    assign bus.rsp_valid = rst_n & (r_count != '0);
    assign w_pop         = bus.rsp_valid & bus.rsp_ready;
    assign w_push        = rst_n & r_v[3] & ~bus.flush;
    assign w_flushed     = {2'b00, r_v[0]} + {2'b00, r_v[1]} + {2'b00, r_v[2]} + {2'b00, r_v[3]};

    assign {bus.rsp_id, bus.rsp_cout, bus.rsp_sum} = r_mem[r_rdPtr];

    // Stage tracking mirrors the adder; a flush squashes every stage including the one about to retire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v           <= '0;
            r_id          <= '0;
            r_outstanding <= '0;
        end else begin
            r_v           <= bus.flush ? 4'b0000 : {r_v[2:0], w_issue};
            r_id          <= {r_id[2:0], w_issue1};
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_pop)
                           - (bus.flush ? CW'(w_flushed) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {r_id[3], bus.pipe_cout, bus.pipe_sum};
        end
    end
endmodule

// File: doc/adder_pipe_scheduler.md
# adder_pipe_scheduler

Front-end controller for the 4-stage 32-bit stallable pipelined adder. It arbitrates between two requesters and issues at most one operand pair per cycle into the adder. It tracks each in-flight operation with a valid/ID shift register aligned to the adder stages. Results are collected into a response FIFO with valid/ready backpressure, and a flush request is turned into the adder's per-stage refresh controls.

## Interface
Parameters:
- DEPTH, 8: response FIFO entries and maximum outstanding operations; legal range 5..16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req0_valid / req1_valid  in  1  requester has operands.
- req0_ready / req1_ready  out  1  operands accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- req0_cin / req1_cin  in  1  carry-in.
- flush  in  1  squash all in-flight operations.
- pipe_a, pipe_b  out  32  adder operands (combinational from granted requester, 0 when idle).
- pipe_cin  out  1  adder carry-in.
- pipe_halt  out  4  adder stage halt; constant 4'b0000.
- pipe_refresh  out  4  adder stage refresh.
- pipe_sum  in  32  adder sum_out.
- pipe_cout  in  1  adder c_out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_sum  out  32  result sum.
- rsp_cout  out  1  result carry.
- rsp_id  out  1  originating requester (0/1).

## Operation
- Reset (rst_n=0 at an edge):
  - outstanding counter, FIFO pointers and count, stage valid bits, and RR pointer (→0) are cleared.
  - While rst_n=0: rsp_valid=0, req*_ready=0, pipe_refresh=4'b1111, pipe_a/b/cin=0.
- Issue is permitted when outstanding < DEPTH, flush=0, and rst_n=1.
- Grant:
  - With one valid requester, that requester wins.
  - With both valid, the winner is per Configuration.
  - Only the granted requester's ready is 1.
  - Ready does not depend on that requester's own valid.
- On issue, stage valid bit v[0] and id[0] are set. Each cycle, v/id shift v[0]→v[1]→v[2]→v[3].
- When v[3]=1, {pipe_cout, pipe_sum, id[3]} is written into the FIFO at the next edge.
- FIFO push never overflows, because the outstanding count bounds occupancy.
- Outstanding counter:
  - +1 on issue; −1 on response pop (rsp_valid & rsp_ready).
  - Simultaneous issue and pop leaves it unchanged.
  - On flush, it is reduced by the number of set v bits.
- Flush:
  - In the flush cycle, pipe_refresh=4'b1111 and all v bits clear at the edge.
  - The stage-3 result present that cycle is discarded, not pushed.
  - FIFO contents (completed results) are retained.
  - A pop in the flush cycle still completes.
- The adder is never halted. Backpressure is handled entirely by credit (outstanding) limiting.
- Sum width is 32 bits; carry-out is reported separately. There is no saturation.

## Timing
- Issue edge E0: the adder samples pipe_a/b/cin at E0.
- The result is on pipe_sum after E3 and is pushed at E4.
- rsp_valid is high in the cycle after E4 when the FIFO was empty: 4 edges issue→response.
- rsp_* are registered FIFO-head outputs and stay stable while rsp_valid & !rsp_ready.
- Sustained throughput is 1 op/cycle with rsp_ready=1.
- With rsp_ready=0, exactly DEPTH ops are accepted, then ready drops.
- Ready returns the cycle after the first pop.
- A pop and push on the same edge with the FIFO empty is not possible. Push into an empty FIFO makes rsp_valid high the next cycle (no bypass).
- FIFO pointers wrap modulo DEPTH. Full is detected by count, not by pointer equality.

## Configuration
- PIPE_ADDER_RR_EN defined: round-robin arbitration.
  - On contention, the grant goes to the requester not granted at the most recent issue.
  - The pointer updates only on issue.
- Not defined: fixed priority. req0 always wins on contention, and req1 can starve.

## Test plan
- Single op: after reset, req0 a=32'hFFFF_FFFF, b=1, cin=0 → 4 edges later rsp_valid=1, rsp_sum=0, rsp_cout=1, rsp_id=0.
- Back-to-back: 20 ops from req1 with rsp_ready=1 → ready stays 1, responses arrive in order, one per cycle, all with id=1.
- Backpressure: rsp_ready=0, req0 streaming → exactly 8 accepts, then ready=0. Raising rsp_ready drains 8 results in order, and ready reasserts the cycle after the first pop.
- Flush: 3 ops in flight plus 2 in the FIFO, flush pulsed → pipe_refresh=4'hF for one cycle, only the 2 buffered results are returned, and the outstanding count equals 2.
- Contention: both requesters continuously valid → with PIPE_ADDER_RR_EN, rsp_id alternates 0,1,0,1; without it, all ids are 0.
- Reset mid-operation: rst_n low with 4 in flight and 3 buffered → next cycle rsp_valid=0 and pipe_refresh=4'hF. After release, a new op returns correctly.
